// File: rtl/instruction_decode_if.sv
// rtl/instruction_decode_if.sv - fetch/WB-to-decode and decode-to-execute signal bundle
// Purpose : groups every instruction_decode signal except clk/rst.
// Modports: master - fetch/WB/execute side (drives state, PC/IR, WB write port)
//           slave  - the decode stage (drives redirects, stall and the ID/EX bundle)
interface instruction_decode_if;
    logic [1:0]  curr_state;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        jump;
    logic        jal_swit;
    logic        jr_swit;
    logic        branch;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;
    logic        stall;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src_imm;
    logic        ex_reg_we;
    logic        ex_mem_read;
    logic        ex_mem_write;

    modport master (
        output curr_state, if_pc, if_ir, wb_we, wb_addr, wb_data,
        input  jump, jal_swit, jr_swit, branch, jump_addr, branch_addr, stall,
        input  ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_alu_op,
        input  ex_alu_src_imm, ex_reg_we, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  curr_state, if_pc, if_ir, wb_we, wb_addr, wb_data,
        output jump, jal_swit, jr_swit, branch, jump_addr, branch_addr, stall,
        output ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_alu_op,
        output ex_alu_src_imm, ex_reg_we, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: register file, jump/branch resolution, hazard stall, ID/EX register
// Purpose : decodes the fetched instruction, reads the 32x32 register file, resolves J/JAL/JR and
//           BEQ/BNE in this stage (combinational redirect to fetch), stalls on load-use and
//           branch/JR operand hazards, squashes the wrong-path slot after a taken redirect and
//           registers the ID/EX bundle.
// Ports   : clk, rst (synchronous, active-high)
//           id (instruction_decode_if.slave):
//             in  curr_state, if_pc, if_ir, wb_we, wb_addr, wb_data
//             out jump, jal_swit, jr_swit, branch, jump_addr, branch_addr, stall (combinational)
//             out ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_alu_op,
//                 ex_alu_src_imm, ex_reg_we, ex_mem_read, ex_mem_write (registered)
// Config  : define WB_BYPASS_EN to forward the same-cycle WB write to register-file reads.
module instruction_decode #(
    parameter int         RF_DEPTH = 32,
    parameter logic [1:0] RUN_CODE = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_decode_if.slave  id
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_LINK = 3'd5;

    logic [31:0] rf [RF_DEPTH];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        unused_shamt;

    assign opcode       = id.if_ir[31:26];
    assign rs           = id.if_ir[25:21];
    assign rt           = id.if_ir[20:16];
    assign rd           = id.if_ir[15:11];
    assign funct        = id.if_ir[5:0];
    assign imm_sext     = {{16{id.if_ir[15]}}, id.if_ir[15:0]};
    assign unused_shamt = ^id.if_ir[10:6];

`ifdef WB_BYPASS_EN
    // Write-through: a read of the register being written this cycle sees the new value.
    assign rs_val = (rs == 5'd0) ? 32'd0 :
                    (id.wb_we && id.wb_addr == rs) ? id.wb_data : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 :
                    (id.wb_we && id.wb_addr == rt) ? id.wb_data : rf[rt];
`else
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];
`endif

    // Decoded controls for the instruction currently in if_ir
    logic       dec_valid;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic [4:0] dec_rd;
    logic [2:0] dec_op;
    logic       dec_src_imm;
    logic       dec_reg_we;
    logic       dec_mem_read;
    logic       dec_mem_write;

    always_comb begin
        dec_valid     = 1'b0;
        uses_rs       = 1'b0;
        uses_rt       = 1'b0;
        is_beq        = 1'b0;
        is_bne        = 1'b0;
        is_j          = 1'b0;
        is_jal        = 1'b0;
        is_jr         = 1'b0;
        dec_rd        = 5'd0;
        dec_op        = ALU_ADD;
        dec_src_imm   = 1'b0;
        dec_reg_we    = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_valid  = 1'b1;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
                dec_rd     = rd;
                dec_reg_we = 1'b1;
                case (funct)
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_SUB:  dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_SLT:  dec_op = ALU_SLT;
                    FN_JR: begin
                        is_jr      = 1'b1;
                        uses_rt    = 1'b0;
                        dec_rd     = 5'd0;
                        dec_reg_we = 1'b0;
                    end
                    default: begin
                        dec_valid  = 1'b0;
                        uses_rs    = 1'b0;
                        uses_rt    = 1'b0;
                        dec_rd     = 5'd0;
                        dec_reg_we = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_valid    = 1'b1;
                uses_rs      = 1'b1;
                dec_rd       = rt;
                dec_src_imm  = 1'b1;
                dec_reg_we   = 1'b1;
                dec_mem_read = 1'b1;
            end
            OP_SW: begin
                dec_valid     = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                dec_src_imm   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_ADDI: begin
                dec_valid   = 1'b1;
                uses_rs     = 1'b1;
                dec_rd      = rt;
                dec_src_imm = 1'b1;
                dec_reg_we  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_valid = 1'b1;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                is_beq    = (opcode == OP_BEQ);
                is_bne    = (opcode == OP_BNE);
                dec_op    = ALU_SUB;
            end
            OP_J: begin
                dec_valid = 1'b1;
                is_j      = 1'b1;
            end
            OP_JAL: begin
                dec_valid  = 1'b1;
                is_jal     = 1'b1;
                dec_rd     = 5'd31;
                dec_op     = ALU_LINK;
                dec_reg_we = 1'b1;
            end
            default: ;
        endcase
    end

    logic ex_valid_q;
    logic ex_reg_we_q;
    logic ex_mem_read_q;
    logic [4:0] ex_rd_q;
    logic squash;

    logic run_ok;
    logic load_use;
    logic br_hazard;
    logic hazard;
    logic issue;
    logic operands_eq;
    logic redirect;

    // Decode does work only when running, out of reset, and not in the wrong-path slot.
    assign run_ok = !rst && (id.curr_state == RUN_CODE) && !squash;

    assign load_use  = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                       ((uses_rs && rs == ex_rd_q) || (uses_rt && rt == ex_rd_q));
    // Branches/JR compare operands in this stage, so any in-flight ALU result is too late.
    assign br_hazard = ex_valid_q && ex_reg_we_q && (ex_rd_q != 5'd0) &&
                       (((is_beq || is_bne || is_jr) && rs == ex_rd_q) ||
                        ((is_beq || is_bne) && rt == ex_rd_q));
    assign hazard    = dec_valid && (load_use || br_hazard);
    assign issue     = run_ok && dec_valid && !hazard;

    assign operands_eq = (rs_val == rt_val);

    assign id.stall       = run_ok && hazard;
    assign id.jump        = issue && is_j;
    assign id.jal_swit    = issue && is_jal;
    assign id.jr_swit     = issue && is_jr;
    assign id.branch      = issue && ((is_beq && operands_eq) || (is_bne && !operands_eq));
    assign id.jump_addr   = is_jr ? rs_val : {id.if_pc[31:28], id.if_ir[25:0], 2'b00};
    assign id.branch_addr = id.if_pc + {imm_sext[29:0], 2'b00};

    assign redirect = id.jump || id.jal_swit || id.jr_swit || id.branch;

    // Register file: WB writes land regardless of stall/squash/run state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (id.wb_we && id.wb_addr != 5'd0) begin
            rf[id.wb_addr] <= id.wb_data;
        end
    end

    logic [31:0] ex_pc_q;
    logic [31:0] ex_rs_val_q;
    logic [31:0] ex_rt_val_q;
    logic [31:0] ex_imm_q;
    logic [2:0]  ex_alu_op_q;
    logic        ex_alu_src_imm_q;
    logic        ex_mem_write_q;

    // ID/EX register; anything not issued (stall, squash, unknown, not running) is an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash           <= 1'b0;
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= 32'd0;
            ex_rs_val_q      <= 32'd0;
            ex_rt_val_q      <= 32'd0;
            ex_imm_q         <= 32'd0;
            ex_rd_q          <= 5'd0;
            ex_alu_op_q      <= 3'd0;
            ex_alu_src_imm_q <= 1'b0;
            ex_reg_we_q      <= 1'b0;
            ex_mem_read_q    <= 1'b0;
            ex_mem_write_q   <= 1'b0;
        end else begin
            // redirect is already zero outside RUN and during the squash slot, so this also clears the flag.
            squash <= redirect;
            if (issue) begin
                ex_valid_q       <= 1'b1;
                ex_pc_q          <= id.if_pc;
                ex_rs_val_q      <= rs_val;
                ex_rt_val_q      <= rt_val;
                ex_imm_q         <= imm_sext;
                ex_rd_q          <= dec_rd;
                ex_alu_op_q      <= dec_op;
                ex_alu_src_imm_q <= dec_src_imm;
                ex_reg_we_q      <= dec_reg_we;
                ex_mem_read_q    <= dec_mem_read;
                ex_mem_write_q   <= dec_mem_write;
            end else begin
                ex_valid_q       <= 1'b0;
                ex_pc_q          <= 32'd0;
                ex_rs_val_q      <= 32'd0;
                ex_rt_val_q      <= 32'd0;
                ex_imm_q         <= 32'd0;
                ex_rd_q          <= 5'd0;
                ex_alu_op_q      <= 3'd0;
                ex_alu_src_imm_q <= 1'b0;
                ex_reg_we_q      <= 1'b0;
                ex_mem_read_q    <= 1'b0;
                ex_mem_write_q   <= 1'b0;
            end
        end
    end

    assign id.ex_valid       = ex_valid_q;
    assign id.ex_pc          = ex_pc_q;
    assign id.ex_rs_val      = ex_rs_val_q;
    assign id.ex_rt_val      = ex_rt_val_q;
    assign id.ex_imm         = ex_imm_q;
    assign id.ex_rd          = ex_rd_q;
    assign id.ex_alu_op      = ex_alu_op_q;
    assign id.ex_alu_src_imm = ex_alu_src_imm_q;
    assign id.ex_reg_we      = ex_reg_we_q;
    assign id.ex_mem_read    = ex_mem_read_q;
    assign id.ex_mem_write   = ex_mem_write_q;
endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - self-checking bench for instruction_decode
module tb_instruction_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instruction_decode_if bus ();

    instruction_decode dut (
        .clk (clk),
        .rst (rst),
        .id  (bus)
    );

    // Field care bits: 0 valid,1 pc,2 rs,3 rt,4 imm,5 rd,6 op,7 src,8 we,9 mr,10 mw
    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_BUB = 11'h701;
    localparam logic [10:0] M_R   = 11'h7EF;
    localparam logic [10:0] M_CF  = 11'h70F;
    localparam logic [10:0] M_SW  = 11'h79F;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        src;
        logic        we;
        logic        mr;
        logic        mw;
        logic [10:0] care;
    } ex_t;

    ex_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ex_t mk(input logic v, input logic [31:0] pc, input logic [31:0] rsv,
                               input logic [31:0] rtv, input logic [31:0] imm, input logic [4:0] rd,
                               input logic [2:0] op, input logic src, input logic we,
                               input logic mr, input logic mw, input logic [10:0] care);
        ex_t e;
        e.valid = v; e.pc = pc; e.rs = rsv; e.rt = rtv; e.imm = imm; e.rd = rd;
        e.op = op; e.src = src; e.we = we; e.mr = mr; e.mw = mw; e.care = care;
        return e;
    endfunction

    function automatic ex_t zero_all();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL);
    endfunction

    function automatic ex_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_BUB);
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic cyc(input logic [31:0] pc, input logic [31:0] ir, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        bus.if_pc   = pc;
        bus.if_ir   = ir;
        bus.wb_we   = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        #1;
    endtask

    task automatic chk_cf(input string tag, input logic j, input logic jl, input logic jr,
                          input logic br, input logic st);
        check({tag, ".jump"}, {31'd0, bus.jump}, {31'd0, j});
        check({tag, ".jal_swit"}, {31'd0, bus.jal_swit}, {31'd0, jl});
        check({tag, ".jr_swit"}, {31'd0, bus.jr_swit}, {31'd0, jr});
        check({tag, ".branch"}, {31'd0, bus.branch}, {31'd0, br});
        check({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, st});
    endtask

    // Clock edge, then compare the ID/EX bundle against the oldest scoreboard entry.
    task automatic tick(input string tag);
        ex_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_entry"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.care[0])  check({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
            if (e.care[1])  check({tag, ".ex_pc"}, bus.ex_pc, e.pc);
            if (e.care[2])  check({tag, ".ex_rs_val"}, bus.ex_rs_val, e.rs);
            if (e.care[3])  check({tag, ".ex_rt_val"}, bus.ex_rt_val, e.rt);
            if (e.care[4])  check({tag, ".ex_imm"}, bus.ex_imm, e.imm);
            if (e.care[5])  check({tag, ".ex_rd"}, {27'd0, bus.ex_rd}, {27'd0, e.rd});
            if (e.care[6])  check({tag, ".ex_alu_op"}, {29'd0, bus.ex_alu_op}, {29'd0, e.op});
            if (e.care[7])  check({tag, ".ex_alu_src_imm"}, {31'd0, bus.ex_alu_src_imm}, {31'd0, e.src});
            if (e.care[8])  check({tag, ".ex_reg_we"}, {31'd0, bus.ex_reg_we}, {31'd0, e.we});
            if (e.care[9])  check({tag, ".ex_mem_read"}, {31'd0, bus.ex_mem_read}, {31'd0, e.mr});
            if (e.care[10]) check({tag, ".ex_mem_write"}, {31'd0, bus.ex_mem_write}, {31'd0, e.mw});
        end
    endtask

    logic [31:0] exp_r6;

    initial begin
        bus.curr_state = 2'b01;
        bus.if_pc = 0; bus.if_ir = 0; bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        @(posedge clk);
        #1;

        // Reset: two cycles, redirects held low even with a jump presented
        rst = 1'b1;
        cyc(32'h0, enc_j(6'h02, 26'h80), 0, 0, 0);
        chk_cf("rst0", 0, 0, 0, 0, 0);
        sb.push_back(zero_all()); tick("rst0");
        cyc(32'h0, enc_j(6'h02, 26'h80), 0, 0, 0);
        chk_cf("rst1", 0, 0, 0, 0, 0);
        sb.push_back(zero_all()); tick("rst1");
        rst = 1'b0;

        cyc(32'h0, 32'h0, 0, 0, 0);
        chk_cf("idle", 0, 0, 0, 0, 0);
        sb.push_back(zero_all()); tick("idle");

        cyc(32'h0, 32'h0, 1, 5'd1, 32'd5); sb.push_back(bub()); tick("wb_r1");
        cyc(32'h0, 32'h0, 1, 5'd2, 32'd5); sb.push_back(bub()); tick("wb_r2");

        // beq r1,r2,+3 taken; following slot squashed
        cyc(32'h104, enc_i(6'h04, 5'd1, 5'd2, 16'd3), 0, 0, 0);
        chk_cf("beq", 0, 0, 0, 1, 0);
        check("beq.branch_addr", bus.branch_addr, 32'h110);
        sb.push_back(mk(1, 32'h104, 5, 5, 0, 0, 0, 0, 0, 0, 0, M_CF)); tick("beq");
        cyc(32'h108, enc_r(5'd1, 5'd2, 5'd4, 6'h20), 0, 0, 0);
        chk_cf("beq_sq", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("beq_sq");

        // jal 0x40; squash slot holds jr r31 which would also stall: squash wins
        cyc(32'h20, enc_j(6'h03, 26'h40), 0, 0, 0);
        chk_cf("jal", 0, 1, 0, 0, 0);
        check("jal.jump_addr", bus.jump_addr, 32'h100);
        sb.push_back(mk(1, 32'h20, 0, 0, 32'h40, 5'd31, 3'd5, 0, 1, 0, 0, M_ALL)); tick("jal");
        cyc(32'h24, enc_r(5'd31, 5'd0, 5'd0, 6'h08), 0, 0, 0);
        chk_cf("jal_sq", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("jal_sq");

        // Load-use: lw r3,0(r0) then add r4,r3,r1
        cyc(32'h30, enc_i(6'h23, 5'd0, 5'd3, 16'd0), 0, 0, 0);
        chk_cf("lw", 0, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h30, 0, 0, 0, 5'd3, 3'd0, 1, 1, 1, 0, M_ALL)); tick("lw");
        cyc(32'h34, enc_r(5'd3, 5'd1, 5'd4, 6'h20), 0, 0, 0);
        chk_cf("lu_stall", 0, 0, 0, 0, 1);
        sb.push_back(bub()); tick("lu_stall");
        cyc(32'h34, enc_r(5'd3, 5'd1, 5'd4, 6'h20), 0, 0, 0);
        chk_cf("lu_issue", 0, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h34, 0, 5, 0, 5'd4, 3'd0, 0, 1, 0, 0, M_R)); tick("lu_issue");

        // jr r1 with r1=7
        cyc(32'h0, 32'h0, 1, 5'd1, 32'd7); sb.push_back(bub()); tick("wb_r1b");
        cyc(32'h50, enc_r(5'd1, 5'd0, 5'd0, 6'h08), 0, 0, 0);
        chk_cf("jr", 0, 0, 1, 0, 0);
        check("jr.jump_addr", bus.jump_addr, 32'd7);
        sb.push_back(mk(1, 32'h50, 7, 0, 0, 0, 0, 0, 0, 0, 0, M_CF)); tick("jr");

        // r0 write ignored (in the squash slot, writes still land elsewhere)
        cyc(32'h54, 32'h0, 1, 5'd0, 32'd9);
        chk_cf("jr_sq", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("jr_sq");
        cyc(32'h58, enc_r(5'd0, 5'd0, 5'd5, 6'h20), 1, 5'd6, 32'h11);
        sb.push_back(mk(1, 32'h58, 0, 0, 0, 5'd5, 3'd0, 0, 1, 0, 0, M_R)); tick("r0_read");

        // Same-cycle WB write vs read of r6
`ifdef WB_BYPASS_EN
        exp_r6 = 32'hAA;
`else
        exp_r6 = 32'h11;
`endif
        cyc(32'h5C, enc_i(6'h08, 5'd6, 5'd7, 16'd1), 1, 5'd6, 32'hAA);
        sb.push_back(mk(1, 32'h5C, exp_r6, 0, 1, 5'd7, 3'd0, 1, 1, 0, 0, M_ALL)); tick("bypass");
        cyc(32'h60, enc_i(6'h08, 5'd6, 5'd7, 16'd1), 0, 0, 0);
        sb.push_back(mk(1, 32'h60, 32'hAA, 0, 1, 5'd7, 3'd0, 1, 1, 0, 0, M_ALL)); tick("after_wb");

        // Branch operand stall: addi r8 then beq r8,r1
        cyc(32'h64, enc_i(6'h08, 5'd0, 5'd8, 16'd5), 0, 0, 0);
        sb.push_back(mk(1, 32'h64, 0, 0, 5, 5'd8, 3'd0, 1, 1, 0, 0, M_ALL)); tick("addi_r8");
        cyc(32'h68, enc_i(6'h04, 5'd8, 5'd1, 16'd2), 0, 0, 0);
        chk_cf("br_stall", 0, 0, 0, 0, 1);
        sb.push_back(bub()); tick("br_stall");
        cyc(32'h68, enc_i(6'h04, 5'd8, 5'd1, 16'd2), 0, 0, 0);
        chk_cf("beq_nt", 0, 0, 0, 0, 0);
        sb.push_back(mk(1, 32'h68, 0, 7, 0, 0, 0, 0, 0, 0, 0, M_CF)); tick("beq_nt");

        // bne taken with negative offset
        cyc(32'h200, enc_i(6'h05, 5'd1, 5'd2, 16'hFFFC), 0, 0, 0);
        chk_cf("bne", 0, 0, 0, 1, 0);
        check("bne.branch_addr", bus.branch_addr, 32'h1F0);
        sb.push_back(mk(1, 32'h200, 7, 5, 0, 0, 0, 0, 0, 0, 0, M_CF)); tick("bne");
        cyc(32'h204, enc_i(6'h23, 5'd1, 5'd9, 16'd0), 0, 0, 0);
        chk_cf("bne_sq", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("bne_sq");

        cyc(32'h70, enc_i(6'h2B, 5'd1, 5'd2, 16'd4), 0, 0, 0);
        sb.push_back(mk(1, 32'h70, 7, 5, 4, 0, 0, 1, 0, 0, 1, M_SW)); tick("sw");

        cyc(32'h74, enc_i(6'h3F, 5'd1, 5'd2, 16'd0), 0, 0, 0);
        chk_cf("unknown", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("unknown");

        // Leaving RUN clears a pending squash
        cyc(32'h78, enc_j(6'h03, 26'h10), 0, 0, 0);
        check("jal2.jump_addr", bus.jump_addr, 32'h40);
        sb.push_back(mk(1, 32'h78, 0, 0, 32'h10, 5'd31, 3'd5, 0, 1, 0, 0, M_ALL)); tick("jal2");
        bus.curr_state = 2'b00;
        cyc(32'h7C, enc_j(6'h02, 26'h20), 0, 0, 0);
        chk_cf("halt", 0, 0, 0, 0, 0);
        sb.push_back(bub()); tick("halt");
        bus.curr_state = 2'b01;
        cyc(32'h80, enc_r(5'd1, 5'd2, 5'd9, 6'h22), 0, 0, 0);
        sb.push_back(mk(1, 32'h80, 7, 5, 0, 5'd9, 3'd1, 0, 1, 0, 0, M_R)); tick("sub");
        cyc(32'h84, enc_r(5'd2, 5'd1, 5'd10, 6'h2A), 0, 0, 0);
        sb.push_back(mk(1, 32'h84, 5, 7, 0, 5'd10, 3'd4, 0, 1, 0, 0, M_R)); tick("slt");

        // Reset mid-operation after a taken jump drops the squash and clears the RF
        cyc(32'hF000_0010, enc_j(6'h02, 26'h80), 0, 0, 0);
        chk_cf("j", 1, 0, 0, 0, 0);
        check("j.jump_addr", bus.jump_addr, 32'hF000_0200);
        sb.push_back(mk(1, 32'hF000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, M_CF)); tick("j");
        rst = 1'b1;
        cyc(32'h14, enc_r(5'd1, 5'd2, 5'd11, 6'h20), 0, 0, 0);
        chk_cf("rst_mid", 0, 0, 0, 0, 0);
        sb.push_back(zero_all()); tick("rst_mid");
        rst = 1'b0;
        cyc(32'h18, enc_r(5'd1, 5'd2, 5'd11, 6'h20), 0, 0, 0);
        sb.push_back(mk(1, 32'h18, 0, 0, 0, 5'd11, 3'd0, 0, 1, 0, 0, M_R)); tick("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
